// File: rtl/force_ring_drain_ctrl_pkg.sv
// Shared definitions for the force ring drain controller: phase FSM state
// type, default quiet/watchdog limits and the ring size.
package MD_pkg;

  localparam int NUM_CELLS         = 64;
  localparam int RING_QUIET_CYCLES = 8;
  localparam int RING_WDOG_CYCLES  = 65535;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    DRAIN   = 3'd2,
    QUIET   = 3'd3,
    DONE    = 3'd4
  } ring_ctrl_state_t;

  // The ring counts as busy from phase start until the done cycle.
  function automatic logic ring_busy(input ring_ctrl_state_t s);
    return (s == COLLECT) || (s == DRAIN) || (s == QUIET);
  endfunction

endpackage

// File: rtl/force_ring_drain_ctrl_ring_popcount.sv
// Parameterised combinational population count used for counting ring
// injections and deliveries in a single cycle.
module ring_popcount #(
  parameter int WIDTH = 8,
  parameter int OUT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits,
  output logic [OUT_W-1:0] count
);

  // Sum the set bits; the width holds WIDTH itself even for non-power-of-two sizes.
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + OUT_W'(bits[i]);
    end
  end

endmodule

// File: rtl/force_ring_drain_ctrl.sv
// Force ring phase scheduler: tracks packets in flight on the force output
// ring and per-cell PE completion, and pulses o_force_phase_done once every
// PE has finished and the ring has been drained and quiet for QUIET_CYCLES.
// Optional feature macro: FORCE_RING_WATCHDOG_EN adds o_timeout and a cycle
// watchdog that forces the done pulse if the phase never completes.
module force_ring_drain_ctrl
  import MD_pkg::*;
#(
  parameter int NUM_CELLS    = MD_pkg::NUM_CELLS,
  parameter int CNT_WIDTH    = 16,
  parameter int QUIET_CYCLES = RING_QUIET_CYCLES,
  parameter int WDOG_CYCLES  = RING_WDOG_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_phase_start,
  input  logic [NUM_CELLS-1:0] i_pe_done,
  input  logic [NUM_CELLS-1:0] i_nb_force_valid,
  input  logic [NUM_CELLS-1:0] i_cache_wr_valid,
  input  logic [NUM_CELLS-1:0] i_ring_buf_empty,
  input  logic [NUM_CELLS-1:0] i_nb_valid_ring,
  output logic [2:0]           o_state,
  output logic                 o_ring_busy,
  output logic                 o_force_phase_done,
  output logic [CNT_WIDTH-1:0] o_inflight_cnt,
  output logic                 o_err_underflow
`ifdef FORCE_RING_WATCHDOG_EN
  ,
  output logic                 o_timeout
`endif
);

  localparam int         PC_W       = $clog2(NUM_CELLS + 1);
  localparam int         SUM_W      = CNT_WIDTH + 1;
  localparam logic [7:0] QUIET_LAST = 8'(QUIET_CYCLES - 1);

  ring_ctrl_state_t     state;
  ring_ctrl_state_t     state_next;
  logic [7:0]           quiet_cnt;
  logic [7:0]           quiet_next;
  logic [CNT_WIDTH-1:0] inflight;
  logic [CNT_WIDTH-1:0] inflight_next;
  logic                 err_underflow;
  logic                 underflow;
  logic [NUM_CELLS-1:0] pe_latch;
  logic [PC_W-1:0]      inject_cnt;
  logic [PC_W-1:0]      deliver_cnt;
  logic [SUM_W-1:0]     sum_up;
  logic [SUM_W-1:0]     sum_down;
  logic                 start_ok;
  logic                 all_done;
  logic                 idle_now;
  logic                 busy;
  logic                 wdog_hit;

  ring_popcount #(.WIDTH(NUM_CELLS), .OUT_W(PC_W)) u_inject_pop (
    .bits  (i_nb_force_valid),
    .count (inject_cnt)
  );

  ring_popcount #(.WIDTH(NUM_CELLS), .OUT_W(PC_W)) u_deliver_pop (
    .bits  (i_cache_wr_valid),
    .count (deliver_cnt)
  );

  assign start_ok = i_phase_start && (state == IDLE);
  assign all_done = &pe_latch;
  assign busy     = ring_busy(state);
  assign idle_now = (inflight == '0) && (&i_ring_buf_empty) && !(|i_nb_valid_ring)
                    && !(|i_nb_force_valid) && !(|i_cache_wr_valid);

  // Next in-flight count: add injections first so a same-cycle delivery only
  // underflows when it exceeds everything available, then clamp at both ends.
  always_comb begin
    sum_up        = {1'b0, inflight} + SUM_W'(inject_cnt);
    sum_down      = '0;
    underflow     = 1'b0;
    inflight_next = '0;
    if (SUM_W'(deliver_cnt) > sum_up) begin
      underflow = 1'b1;
    end else begin
      sum_down = sum_up - SUM_W'(deliver_cnt);
      if (sum_down[CNT_WIDTH]) begin
        inflight_next = '1;
      end else begin
        inflight_next = sum_down[CNT_WIDTH-1:0];
      end
    end
  end

  // In-flight counter and sticky underflow flag update every cycle regardless of phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight      <= '0;
      err_underflow <= 1'b0;
    end else begin
      inflight <= inflight_next;
      if (underflow) begin
        err_underflow <= 1'b1;
      end
    end
  end

  // PE completion latch: a new phase clears it, but a done arriving with the start is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pe_latch <= '0;
    end else if (start_ok) begin
      pe_latch <= i_pe_done;
    end else begin
      pe_latch <= pe_latch | i_pe_done;
    end
  end

`ifdef FORCE_RING_WATCHDOG_EN
  logic [31:0] wdog_cnt;
  logic        timeout;

  assign wdog_hit  = busy && (wdog_cnt == 32'(WDOG_CYCLES - 1));
  assign o_timeout = timeout;

  // Watchdog counts busy cycles from phase start; hitting the limit flags a timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_cnt <= '0;
      timeout  <= 1'b0;
    end else if (start_ok) begin
      wdog_cnt <= '0;
      timeout  <= 1'b0;
    end else if (busy) begin
      wdog_cnt <= wdog_cnt + 32'd1;
      if (wdog_hit) begin
        timeout <= 1'b1;
      end
    end
  end
`else
  logic unused_wdog_cfg;

  assign wdog_hit        = 1'b0;
  assign unused_wdog_cfg = ^WDOG_CYCLES;
`endif

  // Phase FSM: quiet_cnt holds how many consecutive idle cycles have been seen,
  // counting the DRAIN cycle that first found the ring idle.
  always_comb begin
    state_next = state;
    quiet_next = quiet_cnt;
    case (state)
      IDLE: begin
        if (i_phase_start) begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (all_done) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (idle_now) begin
          if (QUIET_CYCLES == 1) begin
            state_next = DONE;
            quiet_next = '0;
          end else begin
            state_next = QUIET;
            quiet_next = 8'd1;
          end
        end
      end
      QUIET: begin
        if (!idle_now) begin
          state_next = DRAIN;
          quiet_next = '0;
        end else if (quiet_cnt == QUIET_LAST) begin
          state_next = DONE;
          quiet_next = '0;
        end else begin
          quiet_next = quiet_cnt + 8'd1;
        end
      end
      DONE: begin
        state_next = IDLE;
        quiet_next = '0;
      end
      default: begin
        state_next = IDLE;
        quiet_next = '0;
      end
    endcase
    if (wdog_hit) begin
      state_next = DONE;
      quiet_next = '0;
    end
  end

  // State and quiet counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      quiet_cnt <= '0;
    end else begin
      state     <= state_next;
      quiet_cnt <= quiet_next;
    end
  end

  assign o_state            = state;
  assign o_ring_busy        = busy;
  assign o_force_phase_done = (state == DONE);
  assign o_inflight_cnt     = inflight;
  assign o_err_underflow    = err_underflow;

endmodule

// File: tb/tb_force_ring_drain_ctrl.sv
// Self-checking bench for force_ring_drain_ctrl: a fixed vector table, a few
// hand-written multi-cycle sequences and a randomized run, all compared every
// cycle against a behavioural model of the phase rules.
module tb_force_ring_drain_ctrl;

  localparam int NC = 64;
  localparam int CW = 16;
  localparam int QC = 8;
  localparam int WD = 100;
  localparam logic [NC-1:0] ALL = {NC{1'b1}};
  localparam logic [NC-1:0] NONE = '0;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          phase_start = 1'b0;
  logic [NC-1:0] pe_done = '0;
  logic [NC-1:0] nb_force_valid = '0;
  logic [NC-1:0] cache_wr_valid = '0;
  logic [NC-1:0] ring_buf_empty = '1;
  logic [NC-1:0] nb_valid_ring = '0;
  logic [2:0]    state;
  logic          ring_busy;
  logic          phase_done;
  logic [CW-1:0] inflight_cnt;
  logic          err_underflow;
`ifdef FORCE_RING_WATCHDOG_EN
  logic          timeout;
`endif

  int n_checks = 0;
  int n_errors = 0;

  force_ring_drain_ctrl #(
    .NUM_CELLS(NC), .CNT_WIDTH(CW), .QUIET_CYCLES(QC), .WDOG_CYCLES(WD)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_phase_start      (phase_start),
    .i_pe_done          (pe_done),
    .i_nb_force_valid   (nb_force_valid),
    .i_cache_wr_valid   (cache_wr_valid),
    .i_ring_buf_empty   (ring_buf_empty),
    .i_nb_valid_ring    (nb_valid_ring),
    .o_state            (state),
    .o_ring_busy        (ring_busy),
    .o_force_phase_done (phase_done),
    .o_inflight_cnt     (inflight_cnt),
    .o_err_underflow    (err_underflow)
`ifdef FORCE_RING_WATCHDOG_EN
    ,
    .o_timeout          (timeout)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural model. Phase stages: 0 idle, 1 collecting PE completions,
  // 2 draining (idle_run counts consecutive idle cycles), 3 done cycle.
  int            m_cnt;
  bit            m_err;
  logic [NC-1:0] m_latch;
  int            m_stage;
  int            m_run;
  int            m_wd;
  bit            m_timeout;

  task automatic model_reset();
    m_cnt = 0; m_err = 0; m_latch = '0; m_stage = 0; m_run = 0; m_wd = 0; m_timeout = 0;
  endtask

  task automatic model_step(input logic start, input logic [NC-1:0] pe, inj, del, empty, vring);
    bit idle;
    bit accept;
    int n;
    int nstage;
    int nrun;
    idle   = (m_cnt == 0) && (&empty) && (vring == '0) && (inj == '0) && (del == '0);
    accept = start && (m_stage == 0);
    nstage = m_stage;
    nrun   = m_run;
    case (m_stage)
      0: if (start) nstage = 1;
      1: if (&m_latch) begin nstage = 2; nrun = 0; end
      2: begin
        if (idle) begin
          nrun = m_run + 1;
          if (nrun >= QC) begin nstage = 3; nrun = 0; end
        end else begin
          nrun = 0;
        end
      end
      default: begin nstage = 0; nrun = 0; end
    endcase
`ifdef FORCE_RING_WATCHDOG_EN
    if (m_stage == 1 || m_stage == 2) begin
      m_wd++;
      if (m_wd == WD) begin nstage = 3; nrun = 0; m_timeout = 1; end
    end
    if (accept) begin m_wd = 0; m_timeout = 0; end
`endif
    n = m_cnt + $countones(inj) - $countones(del);
    if (n < 0) begin
      n = 0;
      m_err = 1;
    end else if (n > (1 << CW) - 1) begin
      n = (1 << CW) - 1;
    end
    m_cnt   = n;
    m_latch = (accept ? NONE : m_latch) | pe;
    m_stage = nstage;
    m_run   = nrun;
  endtask

  function automatic logic [2:0] model_state();
    case (m_stage)
      0:       return 3'd0;
      1:       return 3'd1;
      2:       return (m_run > 0) ? 3'd3 : 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  task automatic check_val(input string tag, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s %s: got %0d expected %0d", tag, name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check_val(tag, "state", 64'(state), 64'(model_state()));
    check_val(tag, "inflight_cnt", 64'(inflight_cnt), 64'(m_cnt));
    check_val(tag, "err_underflow", 64'(err_underflow), 64'(m_err));
    check_val(tag, "phase_done", 64'(phase_done), 64'(m_stage == 3));
    check_val(tag, "ring_busy", 64'(ring_busy), 64'(m_stage == 1 || m_stage == 2));
`ifdef FORCE_RING_WATCHDOG_EN
    check_val(tag, "timeout", 64'(timeout), 64'(m_timeout));
`endif
  endtask

  task automatic applyStimulus(input logic start, input logic [NC-1:0] pe, inj, del, empty, vring,
                               input string tag);
    phase_start    = start;
    pe_done        = pe;
    nb_force_valid = inj;
    cache_wr_valid = del;
    ring_buf_empty = empty;
    nb_valid_ring  = vring;
    model_step(start, pe, inj, del, empty, vring);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic idle_inputs();
    phase_start = 0; pe_done = '0; nb_force_valid = '0; cache_wr_valid = '0;
    ring_buf_empty = '1; nb_valid_ring = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    checkOutput("reset");
    rst = 1'b0;
  endtask

  typedef struct {
    logic          start;
    logic [NC-1:0] pe, inj, del, empty, vring;
    logic [2:0]    st;
    logic [CW-1:0] cnt;
    logic          done;
    logic          err;
  } vec_t;

  function automatic vec_t mk(input logic start, input logic [NC-1:0] pe, inj, del, empty, vring,
                              input logic [2:0] st, input logic [CW-1:0] cnt, input logic done, err);
    vec_t v;
    v.start = start; v.pe = pe; v.inj = inj; v.del = del; v.empty = empty; v.vring = vring;
    v.st = st; v.cnt = cnt; v.done = done; v.err = err;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin
    int            peak;
    int            pulses;
    int            done_cyc;
    logic [NC-1:0] inj, del, empty, vring, pe, mask;
    logic          st;
    int            k;

    // Vector table: outputs expected after the clock edge that ends each row.
    tbl.push_back(mk(1, NONE, NONE,     NONE,     ALL, NONE, 3'd1, 0, 0, 0));
    tbl.push_back(mk(0, NONE, 64'hF,    NONE,     ALL, NONE, 3'd1, 4, 0, 0));
    tbl.push_back(mk(0, NONE, 64'hF0,   64'hF,    ALL, NONE, 3'd1, 4, 0, 0));
    tbl.push_back(mk(0, NONE, NONE,     64'h3,    ALL, NONE, 3'd1, 2, 0, 0));
    tbl.push_back(mk(0, ALL,  NONE,     NONE,     ALL, NONE, 3'd1, 2, 0, 0));
    tbl.push_back(mk(0, NONE, NONE,     NONE,     ALL, NONE, 3'd2, 2, 0, 0));
    tbl.push_back(mk(0, NONE, 64'hF00,  64'hF000, ALL, NONE, 3'd2, 2, 0, 0));
    tbl.push_back(mk(0, NONE, NONE,     64'h3,    ALL, NONE, 3'd2, 0, 0, 0));
    tbl.push_back(mk(0, NONE, NONE,     NONE,     ALL, NONE, 3'd3, 0, 0, 0));
    tbl.push_back(mk(0, NONE, NONE,     NONE,     ALL, 64'h8, 3'd2, 0, 0, 0));
    tbl.push_back(mk(0, NONE, NONE,     NONE,     ~64'h20, NONE, 3'd2, 0, 0, 0));
    for (int i = 0; i < QC - 1; i++) begin
      tbl.push_back(mk(0, NONE, NONE, NONE, ALL, NONE, 3'd3, 0, 0, 0));
    end
    tbl.push_back(mk(0, NONE, NONE,     NONE,     ALL, NONE, 3'd4, 0, 1, 0));
    tbl.push_back(mk(0, NONE, NONE,     NONE,     ALL, NONE, 3'd0, 0, 0, 0));
    tbl.push_back(mk(0, NONE, NONE,     64'h1,    ALL, NONE, 3'd0, 0, 0, 1));
    tbl.push_back(mk(1, NONE, NONE,     NONE,     ALL, NONE, 3'd1, 0, 0, 1));

    $display("[TB] vector table: %0d rows", tbl.size());
    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].start, tbl[i].pe, tbl[i].inj, tbl[i].del, tbl[i].empty, tbl[i].vring, "table_model");
      check_val("table", "state", 64'(state), 64'(tbl[i].st));
      check_val("table", "inflight_cnt", 64'(inflight_cnt), 64'(tbl[i].cnt));
      check_val("table", "phase_done", 64'(phase_done), 64'(tbl[i].done));
      check_val("table", "err_underflow", 64'(err_underflow), 64'(tbl[i].err));
    end

    // Asynchronous reset in the middle of DRAIN with five packets in flight.
    $display("[TB] reset mid-drain");
    do_reset();
    applyStimulus(1, NONE, NONE,   NONE, ALL, NONE, "rst_setup");
    applyStimulus(0, ALL,  64'h1F, NONE, ALL, NONE, "rst_setup");
    applyStimulus(0, NONE, NONE,   NONE, ALL, NONE, "rst_setup");
    check_val("rst_pre", "state", 64'(state), 64'd2);
    check_val("rst_pre", "inflight_cnt", 64'(inflight_cnt), 64'd5);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("rst_async", "state", 64'(state), 64'd0);
    check_val("rst_async", "inflight_cnt", 64'(inflight_cnt), 64'd0);
    @(posedge clk);
    #1;
    model_reset();
    checkOutput("rst_next");
    rst = 1'b0;

    // Trickle traffic on cell 0, all PEs finish at cycle 300.
    $display("[TB] trickle phase");
    peak = 0; pulses = 0; done_cyc = -1;
    for (int t = 0; t <= 340; t++) begin
      inj = (t >= 16 && t <= 208 && (t % 16) == 0) ? 64'h1 : NONE;
      del = (t >= 26 && t <= 218 && ((t - 10) % 16) == 0) ? 64'h1 : NONE;
      pe  = (t == 300) ? ALL : NONE;
      applyStimulus(t == 0, pe, inj, del, ALL, NONE, "trickle");
      if (int'(inflight_cnt) > peak) peak = int'(inflight_cnt);
      if (phase_done) begin pulses++; done_cyc = t + 1; end
    end
    check_val("trickle", "done_pulses", 64'(pulses), 64'd1);
    check_val("trickle", "inflight_peak", 64'(peak), 64'd1);
    check_val("trickle", "inflight_final", 64'(inflight_cnt), 64'd0);
    check_val("trickle", "done_cycle", 64'(done_cyc), 64'(300 + QC + 2));

    // Quiet interrupted at quiet count 5 by a valid ring slot on node 3.
    $display("[TB] quiet interruption");
    do_reset();
    pulses = 0; done_cyc = -1;
    for (int t = 0; t <= 40; t++) begin
      applyStimulus(t == 0, (t == 2) ? ALL : NONE, NONE, NONE, ALL, (t == 9) ? 64'h8 : NONE, "quiet_int");
      if (t == 9) check_val("quiet_int", "back_to_drain", 64'(state), 64'd2);
      if (phase_done) begin pulses++; done_cyc = t + 1; end
    end
    check_val("quiet_int", "done_pulses", 64'(pulses), 64'd1);
    check_val("quiet_int", "done_cycle", 64'(done_cyc), 64'(10 + QC));

    // Counter saturation with all cells injecting every cycle.
    $display("[TB] saturation");
    do_reset();
    for (int t = 0; t < 1030; t++) begin
      applyStimulus(t == 0, NONE, ALL, NONE, ALL, NONE, "saturate");
    end
    check_val("saturate", "inflight_max", 64'(inflight_cnt), 64'((1 << CW) - 1));
    applyStimulus(0, NONE, NONE, ALL, ALL, NONE, "saturate_drop");
    check_val("saturate", "inflight_after_del", 64'(inflight_cnt), 64'((1 << CW) - 1 - NC));

`ifdef FORCE_RING_WATCHDOG_EN
    // PE 0 never finishes; the watchdog must force the done pulse.
    $display("[TB] watchdog");
    do_reset();
    pulses = 0; done_cyc = -1;
    for (int t = 0; t <= 120; t++) begin
      applyStimulus(t == 0, (t == 1) ? ~64'h1 : NONE, NONE, NONE, ALL, NONE, "wdog");
      if (phase_done) begin pulses++; done_cyc = t + 1; end
    end
    check_val("wdog", "done_pulses", 64'(pulses), 64'd1);
    check_val("wdog", "done_cycle", 64'(done_cyc), 64'(1 + WD));
    check_val("wdog", "timeout", 64'(timeout), 64'd1);
`endif

    // Randomized run: traffic bursts alternate with draining windows.
    $display("[TB] random run");
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      st = ($urandom_range(0, 7) == 0);
      pe = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      empty = ALL;
      vring = NONE;
      if ($urandom_range(0, 15) == 0) empty[$urandom_range(0, NC - 1)] = 1'b0;
      if ($urandom_range(0, 15) == 0) vring[$urandom_range(0, NC - 1)] = 1'b1;
      if ((i % 64) < 32) begin
        inj = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom}
              & {$urandom, $urandom} & {$urandom, $urandom};
        del = (m_cnt > 8) ? ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom}
              & {$urandom, $urandom} & {$urandom, $urandom}) : NONE;
      end else begin
        inj = NONE;
        k = $urandom_range(0, 6);
        if (k > m_cnt) k = m_cnt;
        mask = ALL;
        del = (k == 0) ? NONE : (mask >> (NC - k));
      end
      if ($urandom_range(0, 499) == 0) del = del | 64'h1;
      applyStimulus(st, pe, inj, del, empty, vring, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
